// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: state encodings and default refclk-cycle timings for the PLL lock supervisor.
package pll_sup_pkg;
    typedef logic [2:0] pll_state_t;
    localparam pll_state_t S_RESET_PLL = 3'd0;
    localparam pll_state_t S_WAIT_LOCK = 3'd1;
    localparam pll_state_t S_STABLE    = 3'd2;
    localparam pll_state_t S_RUN       = 3'd3;
    localparam pll_state_t S_FAULT     = 3'd4;
    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 10000;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRIES   = 4;
    localparam int DEF_CNT_W         = 8;
    function automatic int max3(input int a, input int b, input int c);
        return a > b ? (a > c ? a : c) : (b > c ? b : c);
    endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic single-bit two-flop synchronizer with async active-high reset.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) {q_o, meta_q} <= 2'b00;
        else       {q_o, meta_q} <= {meta_q, d_i};
endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences PLL reset/relock with timeout and bounded retries,
// and holds the system reset until lock has been continuously stable.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    input  logic             restart,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             fault,
    output logic [CNT_W-1:0] loss_count,
    output logic [2:0]       state
);
    localparam int TW = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    logic             locked_s;
    pll_state_t       state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d, eff;
    logic [RW-1:0]    retry_q, retry_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic             pll_rst_q, sys_rst_q, fault_q;
    logic             expire, fail;

    sync_2ff u_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (locked),
        .q_o   (locked_s)
    );

    function automatic logic [TW-1:0] load_of(input pll_state_t s);
        return s == S_RESET_PLL ? TW'(RST_CYCLES)   :
               s == S_WAIT_LOCK ? TW'(LOCK_TIMEOUT) :
               s == S_STABLE    ? TW'(STABLE_CYCLES) : '0;
    endfunction

    // A zero timer means "full period remaining", so the state after reset runs its whole length.
    always_comb begin
        eff     = timer_q == '0 ? load_of(state_q) : timer_q;
        expire  = eff == TW'(1);
        fail    = !locked_s && ((state_q == S_WAIT_LOCK && expire) || state_q == S_STABLE);
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        if (fail) begin
            retry_d = retry_q + 1'b1;
            state_d = retry_d == RW'(MAX_RETRIES) ? S_FAULT : S_RESET_PLL;
        end else if (state_q == S_RESET_PLL && expire) begin
            state_d = S_WAIT_LOCK;
        end else if (state_q == S_WAIT_LOCK && locked_s) begin
            state_d = S_STABLE;
        end else if (state_q == S_STABLE && expire) begin
            state_d = S_RUN;
            retry_d = '0;
        end else if (state_q == S_RUN && !locked_s) begin
            state_d = S_RESET_PLL;
            loss_d  = &loss_q ? loss_q : loss_q + 1'b1;
        end else if (state_q == S_FAULT && restart) begin
            state_d = S_RESET_PLL;
            retry_d = '0;
        end
        timer_d = state_d != state_q ? load_of(state_d) : (eff == '0 ? '0 : eff - 1'b1);
    end

    always_ff @(posedge refclk or posedge rst)
        if (rst) begin
            state_q   <= S_RESET_PLL;
            timer_q   <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            pll_rst_q <= state_d == S_RESET_PLL || state_d == S_FAULT;
            sys_rst_q <= state_d != S_RUN;
            fault_q   <= state_d == S_FAULT;
        end

    assign pll_rst    = pll_rst_q;
    assign sys_rst    = sys_rst_q;
    assign fault      = fault_q;
    assign loss_count = loss_q;
    assign state      = state_q;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed bring-up/loss/timeout/glitch/reset scenarios plus random
// lock activity, all outputs compared each cycle against a behavioural model.
module tb_pll_lock_supervisor;
    localparam int RST_C = 4, LT = 50, SC = 8, MAXR = 2, CW = 4;
    localparam int LMAX = (1 << CW) - 1;

    logic refclk = 1'b0, rst = 1'b1, locked = 1'b0, restart = 1'b0;
    logic pll_rst, sys_rst, fault;
    logic [CW-1:0] loss_count;
    logic [2:0] state;

    int n_assert = 0, n_fail = 0;
    int cnt, hi, early, saw0;

    // Model: state number, edges spent in it, retries, losses, last two lock samples.
    int m_st, m_age, m_retry, m_loss;
    logic [1:0] m_h;

    pll_lock_supervisor #(
        .RST_CYCLES(RST_C), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC),
        .MAX_RETRIES(MAXR), .CNT_W(CW)
    ) dut (
        .refclk(refclk), .rst(rst), .locked(locked), .restart(restart),
        .pll_rst(pll_rst), .sys_rst(sys_rst), .fault(fault),
        .loss_count(loss_count), .state(state)
    );

    always #5 refclk = ~refclk;

    always @(posedge refclk or posedge rst) begin : model
        int ns, na, nr, nl;
        logic ls;
        if (rst) begin
            m_st <= 0; m_age <= 0; m_retry <= 0; m_loss <= 0; m_h <= 2'b00;
        end else begin
            ls = m_h[1];
            ns = m_st; na = m_age + 1; nr = m_retry; nl = m_loss;
            if (m_st == 0 && na == RST_C) ns = 1;
            else if (m_st == 1 && ls) ns = 2;
            else if ((m_st == 1 && na == LT) || (m_st == 2 && !ls)) begin
                nr = nr + 1;
                ns = (nr == MAXR) ? 4 : 0;
            end
            else if (m_st == 2 && na == SC) begin ns = 3; nr = 0; end
            else if (m_st == 3 && !ls) begin ns = 0; nl = (nl == LMAX) ? LMAX : nl + 1; end
            else if (m_st == 4 && restart) begin ns = 0; nr = 0; end
            if (ns != m_st) na = 0;
            m_st <= ns; m_age <= na; m_retry <= nr; m_loss <= nl;
            m_h <= {m_h[0], locked};
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge refclk);
        chk("state", state, m_st);
        chk("pll_rst", pll_rst, m_st == 0 || m_st == 4);
        chk("sys_rst", sys_rst, m_st != 3);
        chk("fault", fault, m_st == 4);
        chk("loss_count", loss_count, m_loss);
    endtask

    task automatic wait_state(input int s, input int lim);
        int n = 0;
        while (state !== 3'(s) && n < lim) begin tick(); n++; end
        chk("wait_state", state, s);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_pll_rst"}, pll_rst, 1);
        chk({tag, "_sys_rst"}, sys_rst, 1);
        chk({tag, "_fault"}, fault, 0);
        chk({tag, "_loss"}, loss_count, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge refclk);
        chk_reset_outputs("reset");
        // 1. nominal bring-up
        rst = 1'b0;
        cnt = 0;
        do begin tick(); cnt++; end while (pll_rst === 1'b1 && cnt < 100);
        chk("t1_pll_rst_len", cnt, RST_C);
        repeat (9) tick();
        locked = 1'b1;
        cnt = 0;
        do begin tick(); cnt++; end while (sys_rst === 1'b1 && cnt < 100);
        chk("t1_sys_rst_lat", cnt, 2 + SC + 1);
        chk("t1_state", state, 3);
        chk("t1_fault", fault, 0);
        // 2. repeated loss in RUN, loss_count saturates
        for (int i = 0; i < 16; i++) begin
            locked = 1'b0;
            cnt = 0; hi = 0;
            for (int k = 0; k < 20; k++) begin
                tick();
                if (sys_rst === 1'b1 && cnt == 0) cnt = k + 1;
                hi += int'(pll_rst);
            end
            chk("t2_loss_lat", cnt, 3);
            chk("t2_pll_pulse", hi, RST_C);
            locked = 1'b1;
            wait_state(3, 200);
            chk("t2_loss_count", loss_count, i < LMAX ? i + 1 : LMAX);
        end
        // 3. timeout into FAULT, then restart
        locked = 1'b0;
        cnt = 0;
        do begin tick(); cnt++; end while (fault !== 1'b1 && cnt < 300);
        chk("t3_to_fault", cnt, 3 + MAXR * (RST_C + LT));
        chk("t3_state", state, 4);
        chk("t3_pll_rst", pll_rst, 1);
        chk("t3_sys_rst", sys_rst, 1);
        locked = 1'b1;
        repeat (10) tick();
        chk("t3_lock_ignored", state, 4);
        locked = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("t3_fault_cleared", fault, 0);
        chk("t3_restart_state", state, 0);
        // 4. glitch in STABLE
        wait_state(1, 20);
        locked = 1'b1;
        wait_state(2, 20);
        repeat (4) tick();
        locked = 1'b0;
        repeat (3) tick();
        locked = 1'b1;
        early = 0; saw0 = 0; cnt = 0;
        while (state !== 3'd3 && cnt < 200) begin
            tick(); cnt++;
            if (state === 3'd0) saw0 = 1;
            if (sys_rst !== 1'b1 && state !== 3'd3) early = 1;
        end
        chk("t4_via_reset", saw0, 1);
        chk("t4_sys_rst_held", early, 0);
        chk("t4_run", state, 3);
        // 5. async reset mid-STABLE, in FAULT; restart ignored in RUN
        locked = 1'b0;
        wait_state(1, 50);
        locked = 1'b1;
        wait_state(2, 20);
        tick();
        #3 rst = 1'b1;
        #1 chk_reset_outputs("t5_stable");
        tick();
        rst = 1'b0;
        locked = 1'b0;
        wait_state(4, 200);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("t5_fault");
        tick();
        rst = 1'b0;
        locked = 1'b1;
        wait_state(3, 100);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("t5_restart_run_state", state, 3);
        chk("t5_restart_run_sys_rst", sys_rst, 0);
        repeat (3) tick();
        chk("t5_still_run", state, 3);
        // random lock activity with sporadic restart requests
        cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            if (cnt == 0) begin
                locked = 1'($urandom_range(0, 1));
                cnt = $urandom_range(1, 120);
            end
            cnt--;
            restart = ($urandom_range(0, 29) == 0);
            tick();
        end
        restart = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
